// File: rtl/audio_dac_scheduler.sv
// audio_dac_scheduler
// Shares the single DAC audio path between four sources. A free-running
// frame counter paces one conversion per sample frame. A round-robin
// arbiter with a minimum-hold window picks the source. The FSM then loads
// the sample, strobes the serializer for two cycles and waits for DONE,
// bounded by a timeout.
module audio_dac_scheduler #(
  parameter int unsigned SAMPLE_DIV  = 5000,
  parameter int unsigned HOLD_FRAMES = 2000,
  parameter int unsigned TIMEOUT     = 4095,
  parameter logic [11:0] MIDSCALE    = 12'h800
) (
  input  logic        CLOCK,
  input  logic        RESETN,
  input  logic [3:0]  REQ,
  input  logic [11:0] SAMPLE0,
  input  logic [11:0] SAMPLE1,
  input  logic [11:0] SAMPLE2,
  input  logic [11:0] SAMPLE3,
  input  logic        DAC_DONE,
  output logic        START,
  output logic [11:0] DATA1,
  output logic [11:0] DATA2,
  output logic [3:0]  GRANT,
  output logic        BUSY,
  output logic        ERR
);

  localparam int DATA_W = 12;
  localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_STROBE,
    S_WAIT
  } state_t;

  // Hold counter advance, pinned at the top of the window.
  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] h);
    return (h >= HOLD_MAX) ? HOLD_MAX : h + HOLD_ONE;
  endfunction

  // Source index to one-hot grant vector.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Frame pacing
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  // FSM and datapath registers
  state_t              state_q;
  logic                start_q;
  logic [DATA_W-1:0]   data_q;
  logic [3:0]          grant_q;
  logic [1:0]          ptr_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                err_q;
  logic                str_q;
  logic [TMO_W-1:0]    tmo_q;

  // Arbitration result, committed only in ARB
  logic [3:0]          arb_grant_d;
  logic [1:0]          arb_ptr_d;
  logic [HOLD_W-1:0]   arb_hold_d;
  logic                arb_found;
  logic [1:0]          arb_cand;
  logic [DATA_W-1:0]   sample_d;

  assign tick = (cnt_q == CNT_LAST);

  // Next frame count: wraps at SAMPLE_DIV-1.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // Free-running sample-frame counter.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Round-robin arbiter with hold window. A pointer rotation of four
  // positions ends on the previous owner itself, so a lone requester is
  // re-granted with a fresh hold window.
  always_comb begin
    arb_grant_d = '0;
    arb_ptr_d   = ptr_q;
    arb_hold_d  = '0;
    arb_found   = 1'b0;
    arb_cand    = ptr_q;
    if (grant_q[ptr_q] && REQ[ptr_q] && (hold_q < HOLD_MAX)) begin
      arb_grant_d = grant_q;
      arb_hold_d  = hold_sat_inc(hold_q);
    end else begin
      for (int i = 1; i <= 4; i++) begin
        arb_cand = ptr_q + 2'(i);
        if (!arb_found && REQ[arb_cand]) begin
          arb_found = 1'b1;
          arb_ptr_d = arb_cand;
        end
      end
      if (arb_found) begin
        arb_grant_d = onehot4(arb_ptr_d);
        arb_hold_d  = HOLD_ONE;
      end
    end
  end

  // Sample selected by the current grant; silence when muted.
  always_comb begin
    sample_d = MIDSCALE;
    if (grant_q != 4'b0000) begin
      case (ptr_q)
        2'd0:    sample_d = SAMPLE0;
        2'd1:    sample_d = SAMPLE1;
        2'd2:    sample_d = SAMPLE2;
        default: sample_d = SAMPLE3;
      endcase
    end
  end

  // Conversion sequencer: IDLE -> ARB -> LOAD -> STROBE(2) -> WAIT.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      data_q  <= MIDSCALE;
      grant_q <= 4'b0000;
      ptr_q   <= 2'd3;
      hold_q  <= '0;
      err_q   <= 1'b0;
      str_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      // A frame tick while a conversion is still in flight is dropped.
      if (tick && (state_q != S_IDLE)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_q <= S_ARB;
          end
        end
        S_ARB: begin
          grant_q <= arb_grant_d;
          ptr_q   <= arb_ptr_d;
          hold_q  <= arb_hold_d;
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          data_q  <= sample_d;
          start_q <= 1'b1;
          str_q   <= 1'b0;
          state_q <= S_STROBE;
        end
        S_STROBE: begin
          // Two-cycle strobe so the half-rate serializer cannot miss it.
          if (!str_q) begin
            str_q <= 1'b1;
          end else begin
            start_q <= 1'b0;
            tmo_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (DAC_DONE) begin
            state_q <= S_IDLE;
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: begin
          start_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign START = start_q;
  assign DATA1 = data_q;
  assign DATA2 = data_q;
  assign GRANT = grant_q;
  assign BUSY  = (state_q != S_IDLE);
  assign ERR   = err_q;

endmodule

// File: tb/tb_audio_dac_scheduler.sv
// Directed bench for audio_dac_scheduler. Instance A uses a 200-cycle frame
// with HOLD_FRAMES=3 and TIMEOUT=100. Instance B uses a 50-cycle frame so
// that a slow DONE overruns the next tick.
module tb_audio_dac_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] s0, s1, s2, s3;
  logic        done_a, done_b;
  logic        start_a, start_b;
  logic [11:0] data1_a, data2_a, data1_b, data2_b;
  logic [3:0]  grant_a, grant_b;
  logic        busy_a, busy_b, err_a, err_b;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  audio_dac_scheduler #(.SAMPLE_DIV(200), .HOLD_FRAMES(3), .TIMEOUT(100), .MIDSCALE(12'h800)) u_dut_a (
    .CLOCK(clk), .RESETN(rst_n), .REQ(req),
    .SAMPLE0(s0), .SAMPLE1(s1), .SAMPLE2(s2), .SAMPLE3(s3),
    .DAC_DONE(done_a), .START(start_a), .DATA1(data1_a), .DATA2(data2_a),
    .GRANT(grant_a), .BUSY(busy_a), .ERR(err_a)
  );

  audio_dac_scheduler #(.SAMPLE_DIV(50), .HOLD_FRAMES(3), .TIMEOUT(100), .MIDSCALE(12'h800)) u_dut_b (
    .CLOCK(clk), .RESETN(rst_n), .REQ(req),
    .SAMPLE0(s0), .SAMPLE1(s1), .SAMPLE2(s2), .SAMPLE3(s3),
    .DAC_DONE(done_b), .START(start_b), .DATA1(data1_b), .DATA2(data2_b),
    .GRANT(grant_b), .BUSY(busy_b), .ERR(err_b)
  );

  // Waits (bounded) for the next START rise; t is the posedge count at that point.
  task automatic wait_start(input bit sel_b, output bit ok, output int t);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ((sel_b ? start_b : start_a) === 1'b1) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
    end
  endtask

  // Serializer stand-in: one-cycle DONE pulse after 'delay' falling edges.
  task automatic serve_done(input bit sel_b, input int delay);
    repeat (delay) @(negedge clk);
    if (sel_b) done_b = 1'b1; else done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    done_b = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    int t, r;
    req = 4'b0000; s0 = 12'h111; s1 = 12'h222; s2 = 12'h333; s3 = 12'h444;
    done_a = 1'b0; done_b = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++; if (start_a !== 1'b0) begin tests_failed++; $display("FAIL reset_start: got %b expected 0", start_a); end
    tests_run++; if (data1_a !== 12'h800) begin tests_failed++; $display("FAIL reset_data1: got %h expected 800", data1_a); end
    tests_run++; if (data2_a !== 12'h800) begin tests_failed++; $display("FAIL reset_data2: got %h expected 800", data2_a); end
    tests_run++; if (grant_a !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b expected 0000", grant_a); end
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    tests_run++; if (err_a !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err_a); end
    rst_n = 1'b1;
    r = cyc;
    wait_start(1'b0, ok, t);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL reset_first_start: no START seen"); end
    tests_run++; if (t - r !== 202) begin tests_failed++; $display("FAIL reset_first_start_time: got %0d expected 202", t - r); end
    tests_run++; if (data1_a !== 12'h800) begin tests_failed++; $display("FAIL reset_mute_data: got %h expected 800", data1_a); end
    serve_done(1'b0, 20);
  endtask

  task automatic test_single_source();
    bit ok;
    int t, t2;
    req = 4'b0100; s0 = 12'h111; s1 = 12'h222; s2 = 12'hABC; s3 = 12'h333;
    wait_start(1'b0, ok, t);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL single_start: no START seen"); end
    tests_run++; if (grant_a !== 4'b0100) begin tests_failed++; $display("FAIL single_grant: got %b expected 0100", grant_a); end
    tests_run++; if (data1_a !== 12'hABC) begin tests_failed++; $display("FAIL single_data1: got %h expected abc", data1_a); end
    tests_run++; if (data2_a !== 12'hABC) begin tests_failed++; $display("FAIL single_data2: got %h expected abc", data2_a); end
    tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b expected 1", busy_a); end
    s2 = 12'h555;
    @(negedge clk);
    tests_run++; if (start_a !== 1'b1) begin tests_failed++; $display("FAIL single_start_2nd: got %b expected 1", start_a); end
    @(negedge clk);
    tests_run++; if (start_a !== 1'b0) begin tests_failed++; $display("FAIL single_start_end: got %b expected 0", start_a); end
    tests_run++; if (data1_a !== 12'hABC) begin tests_failed++; $display("FAIL single_data_hold: got %h expected abc", data1_a); end
    serve_done(1'b0, 38);
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL single_idle_after_done: got %b expected 0", busy_a); end
    wait_start(1'b0, ok, t2);
    tests_run++; if (t2 - t !== 200) begin tests_failed++; $display("FAIL single_period: got %0d expected 200", t2 - t); end
    tests_run++; if (data1_a !== 12'h555) begin tests_failed++; $display("FAIL single_resample: got %h expected 555", data1_a); end
    serve_done(1'b0, 20);
    tests_run++; if (err_a !== 1'b0) begin tests_failed++; $display("FAIL single_err: got %b expected 0", err_a); end
  endtask

  task automatic test_mute();
    bit ok;
    int t;
    req = 4'b0000;
    wait_start(1'b0, ok, t);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL mute_start: no START seen"); end
    tests_run++; if (grant_a !== 4'b0000) begin tests_failed++; $display("FAIL mute_grant: got %b expected 0000", grant_a); end
    tests_run++; if (data1_a !== 12'h800) begin tests_failed++; $display("FAIL mute_data1: got %h expected 800", data1_a); end
    tests_run++; if (data2_a !== 12'h800) begin tests_failed++; $display("FAIL mute_data2: got %h expected 800", data2_a); end
    // DONE during the strobe must be ignored.
    done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    tests_run++; if (start_a !== 1'b1) begin tests_failed++; $display("FAIL mute_strobe_kept: got %b expected 1", start_a); end
    @(negedge clk);
    tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL mute_wait_entered: got %b expected 1", busy_a); end
    serve_done(1'b0, 20);
  endtask

  task automatic test_hold_rotation();
    bit ok;
    int t;
    logic [3:0]  exp_g [12] = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b1000,
                                4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
    logic [11:0] exp_d;
    s0 = 12'h123; s1 = 12'h456; s2 = 12'hABC; s3 = 12'hFED;
    req = 4'b1001;
    for (int f = 0; f < 12; f++) begin
      wait_start(1'b0, ok, t);
      exp_d = (exp_g[f] == 4'b1000) ? 12'hFED : 12'h123;
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL hold_start f%0d: no START seen", f); end
      tests_run++; if (grant_a !== exp_g[f]) begin tests_failed++; $display("FAIL hold_grant f%0d: got %b expected %b", f, grant_a, exp_g[f]); end
      tests_run++; if (data1_a !== exp_d) begin tests_failed++; $display("FAIL hold_data f%0d: got %h expected %h", f, data1_a, exp_d); end
      if (f == 4) req = 4'b1000;
      if (f == 8) req = 4'b1001;
      serve_done(1'b0, 10);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t, t2;
    req = 4'b0100; s2 = 12'hABC;
    // DONE arriving on the very cycle the timeout fires wins.
    wait_start(1'b0, ok, t);
    repeat (101) @(negedge clk);
    done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    tests_run++; if (err_a !== 1'b0) begin tests_failed++; $display("FAIL tmo_done_wins_err: got %b expected 0", err_a); end
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL tmo_done_wins_idle: got %b expected 0", busy_a); end
    wait_start(1'b0, ok, t);
    repeat (101) @(negedge clk);
    tests_run++; if (err_a !== 1'b0) begin tests_failed++; $display("FAIL tmo_early_err: got %b expected 0", err_a); end
    tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL tmo_still_wait: got %b expected 1", busy_a); end
    @(negedge clk);
    tests_run++; if (err_a !== 1'b1) begin tests_failed++; $display("FAIL tmo_err: got %b expected 1", err_a); end
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL tmo_idle: got %b expected 0", busy_a); end
    wait_start(1'b0, ok, t2);
    tests_run++; if (t2 - t !== 200) begin tests_failed++; $display("FAIL tmo_next_frame: got %0d expected 200", t2 - t); end
    tests_run++; if (grant_a !== 4'b0100) begin tests_failed++; $display("FAIL tmo_next_grant: got %b expected 0100", grant_a); end
    tests_run++; if (data1_a !== 12'hABC) begin tests_failed++; $display("FAIL tmo_next_data: got %h expected abc", data1_a); end
    serve_done(1'b0, 20);
    tests_run++; if (err_a !== 1'b1) begin tests_failed++; $display("FAIL tmo_err_sticky: got %b expected 1", err_a); end
  endtask

  task automatic test_overrun_and_reset();
    bit ok;
    int t, t2, r;
    req = 4'b0100; s2 = 12'hABC;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    wait_start(1'b1, ok, t);
    tests_run++; if (t - r !== 52) begin tests_failed++; $display("FAIL ovr_first_start: got %0d expected 52", t - r); end
    repeat (47) @(negedge clk);
    tests_run++; if (err_b !== 1'b0) begin tests_failed++; $display("FAIL ovr_err_before: got %b expected 0", err_b); end
    tests_run++; if (busy_b !== 1'b1) begin tests_failed++; $display("FAIL ovr_busy: got %b expected 1", busy_b); end
    @(negedge clk);
    tests_run++; if (err_b !== 1'b1) begin tests_failed++; $display("FAIL ovr_err: got %b expected 1", err_b); end
    serve_done(1'b1, 12);
    tests_run++; if (busy_b !== 1'b0) begin tests_failed++; $display("FAIL ovr_idle: got %b expected 0", busy_b); end
    wait_start(1'b1, ok, t2);
    tests_run++; if (t2 - t !== 100) begin tests_failed++; $display("FAIL ovr_tick_dropped: got %0d expected 100", t2 - t); end
    tests_run++; if (data1_b !== 12'hABC) begin tests_failed++; $display("FAIL ovr_data: got %h expected abc", data1_b); end
    @(negedge clk);
    tests_run++; if (start_b !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_start: got %b expected 1", start_b); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (start_b !== 1'b0) begin tests_failed++; $display("FAIL rst_async_start: got %b expected 0", start_b); end
    tests_run++; if (data1_b !== 12'h800) begin tests_failed++; $display("FAIL rst_async_data1: got %h expected 800", data1_b); end
    tests_run++; if (data2_b !== 12'h800) begin tests_failed++; $display("FAIL rst_async_data2: got %h expected 800", data2_b); end
    tests_run++; if (grant_b !== 4'b0000) begin tests_failed++; $display("FAIL rst_async_grant: got %b expected 0000", grant_b); end
    tests_run++; if (err_b !== 1'b0) begin tests_failed++; $display("FAIL rst_async_err: got %b expected 0", err_b); end
    tests_run++; if (busy_b !== 1'b0) begin tests_failed++; $display("FAIL rst_async_busy: got %b expected 0", busy_b); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_mute();
    test_hold_rotation();
    test_timeout();
    test_overrun_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
